cmp_stream_scheduler: RTL and testbench



---
 rtl/cmp_stream_scheduler.sv | 162 ++++++++++++++++
 tb/tb_cmp_stream_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_stream_scheduler.sv
// Round-robin scheduler sharing one file-compare engine between NUM_REQ result streams.
// Define CMP_SCHED_TIMEOUT_EN to add a per-grant idle timeout and the timeout_flag output.
module cmp_stream_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int SEGS_PER_STREAM = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ-1:0]            s_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          cmp_start,
  output logic                          cmp_enable,
  output logic [DATA_WIDTH-1:0]         cmp_data,
  input  logic                          cmp_done,
  input  logic                          cmp_pass,
  output logic [NUM_REQ-1:0]            stream_pass,
  output logic [NUM_REQ*4-1:0]          seg_cnt,
`ifdef CMP_SCHED_TIMEOUT_EN
  output logic                          timeout_flag,
`endif
  output logic                          all_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ARB, XFER, WAIT} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        gidx;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        next_rr;
  logic                    pick_valid;
  logic [3:0]              cnt [NUM_REQ];
  logic [NUM_REQ-1:0]      eligible;
  logic                    all_full;
  logic                    in_seg;
  logic                    beat;
  logic                    seg_end;
  logic                    seg_ok;
  logic                    timeout_hit;
  logic [DATA_WIDTH-1:0]   g_data;
  int                      idx;

  always_comb begin
    eligible = '0;
    all_full = 1'b1;
    seg_cnt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i]       = req[i] && (cnt[i] < 4'(SEGS_PER_STREAM));
      all_full          = all_full && (cnt[i] == 4'(SEGS_PER_STREAM));
      seg_cnt[i*4 +: 4] = cnt[i];
    end
  end

  // Scan downwards so the closest eligible stream at or after rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = idx[IDX_W-1:0];
      end
    end
  end

  assign next_rr = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign g_data  = s_data[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign in_seg  = (state == XFER) || (state == WAIT);
  assign beat    = (state == XFER) && s_valid[gidx] && s_ready[gidx];
  assign seg_end = in_seg && (cmp_done || timeout_hit);
  // An early done or a timeout always counts as a failed segment.
  assign seg_ok  = (state == WAIT) && cmp_done && cmp_pass;

`ifdef CMP_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = in_seg && !beat && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (timeout_hit && !cmp_done) timeout_flag <= 1'b1;
      if (!in_seg || beat) to_cnt <= '0;
      else                 to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt         <= '0;
      gidx        <= '0;
      rr_ptr      <= '0;
      s_ready     <= '0;
      cmp_start   <= 1'b0;
      cmp_enable  <= 1'b0;
      cmp_data    <= '0;
      stream_pass <= '1;
      all_done    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      cmp_start <= 1'b0;
      all_done  <= all_done | all_full;
      if (seg_end) begin
        stream_pass[gidx] <= stream_pass[gidx] & seg_ok;
        if (cnt[gidx] < 4'(SEGS_PER_STREAM)) cnt[gidx] <= cnt[gidx] + 4'd1;
        rr_ptr     <= next_rr;
        gnt        <= '0;
        s_ready    <= '0;
        cmp_enable <= 1'b0;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            cmp_enable <= 1'b0;
            if (pick_valid && !all_done) begin
              gidx      <= pick_idx;
              gnt       <= NUM_REQ'(1) << pick_idx;
              cmp_start <= 1'b1;
              state     <= ARB;
            end
          end
          ARB: begin
            s_ready <= gnt;
            state   <= XFER;
          end
          XFER: begin
            cmp_enable <= beat;
            if (beat) begin
              cmp_data <= g_data;
              if (s_last[gidx]) begin
                s_ready <= '0;
                state   <= WAIT;
              end
            end
          end
          WAIT: cmp_enable <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmp_stream_scheduler.sv
// Directed scoreboard bench for cmp_stream_scheduler; forwarded beats are checked against a queue
// of driven beats, including the one-cycle latency. Timeout steps run when CMP_SCHED_TIMEOUT_EN is defined.
module tb_cmp_stream_scheduler;

  localparam int NR   = 4;
  localparam int DW   = 32;
  localparam int SEGS = 4;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   s_valid = '0;
  logic [NR-1:0]   s_last = '0;
  logic [NR*DW-1:0] s_data = '0;
  logic [NR-1:0]   s_ready;
  logic [NR-1:0]   gnt;
  logic            cmp_start;
  logic            cmp_enable;
  logic [DW-1:0]   cmp_data;
  logic            cmp_done = 1'b0;
  logic            cmp_pass = 1'b0;
  logic [NR-1:0]   stream_pass;
  logic [NR*4-1:0] seg_cnt;
  logic            all_done;
`ifdef CMP_SCHED_TIMEOUT_EN
  logic            timeout_flag;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int starts = 0;
  bit watch3 = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  beat_t sb[$];

  cmp_stream_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .SEGS_PER_STREAM(SEGS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .s_valid(s_valid), .s_last(s_last),
    .s_data(s_data), .s_ready(s_ready), .gnt(gnt), .cmp_start(cmp_start),
    .cmp_enable(cmp_enable), .cmp_data(cmp_data), .cmp_done(cmp_done),
    .cmp_pass(cmp_pass), .stream_pass(stream_pass), .seg_cnt(seg_cnt),
`ifdef CMP_SCHED_TIMEOUT_EN
    .timeout_flag(timeout_flag),
`endif
    .all_done(all_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Engine-side monitor: every cmp_enable must match the oldest accepted beat, one cycle later.
  always @(negedge clk) begin
    beat_t b;
    if (reset_n) begin
      if (cmp_start) starts++;
      if (cmp_enable) begin
        if (sb.size() == 0) checkOutput("spurious_enable", cmp_enable, 1'b0);
        else begin
          b = sb.pop_front();
          checkOutput("cmp_data", cmp_data, b.data);
          checkOutput("beat_latency", cyc, b.cyc + 1);
        end
      end
      if (watch3) checkOutput("s_ready3", s_ready[3], 1'b0);
    end
  end

  task automatic applyStimulus_reset();
    reset_n = 1'b0; req = '0; s_valid = '0; s_last = '0; cmp_done = 1'b0; cmp_pass = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    checkOutput("rst_gnt", gnt, '0);
    checkOutput("rst_s_ready", s_ready, '0);
    checkOutput("rst_cmp_enable", cmp_enable, 1'b0);
    checkOutput("rst_stream_pass", stream_pass, 4'hF);
    checkOutput("rst_seg_cnt", seg_cnt, 16'h0000);
    checkOutput("rst_all_done", all_done, 1'b0);
`ifdef CMP_SCHED_TIMEOUT_EN
    checkOutput("rst_timeout_flag", timeout_flag, 1'b0);
`endif
    reset_n = 1'b1;
    starts = 0;
    @(negedge clk);
  endtask

  task automatic waitGrant(input int idx);
    int n = 0;
    logic [NR-1:0] exp;
    exp = 4'b0001 << idx;
    while (gnt == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("gnt_s%0d", idx), gnt, exp);
    checkOutput("start_with_gnt", cmp_start, 1'b1);
  endtask

  task automatic applyStimulus(input int idx, input logic [DW-1:0] d, input bit last);
    int n = 0;
    bit done = 1'b0;
    beat_t b;
    s_valid[idx] = 1'b1;
    s_last[idx] = last;
    s_data[idx*DW +: DW] = d;
    while (!done && n < 50) begin
      if (s_ready[idx]) begin
        b.data = d;
        b.cyc = cyc;
        sb.push_back(b);
        done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    s_valid[idx] = 1'b0;
    s_last[idx] = 1'b0;
    if (!done) checkOutput("beat_accept", s_ready[idx], 1'b1);
  endtask

  task automatic engineDone(input bit pass);
    cmp_done = 1'b1;
    cmp_pass = pass;
    @(negedge clk);
    cmp_done = 1'b0;
    cmp_pass = 1'b0;
  endtask

  task automatic doSegment(input int idx, input int nbeats, input logic [DW-1:0] base,
                           input bit pass, input bit dropReq);
    waitGrant(idx);
    if (dropReq) req[idx] = 1'b0;
    for (int b = 0; b < nbeats; b++) applyStimulus(idx, base * (b + 1), b == nbeats - 1);
    engineDone(pass);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Single stream, three beats.
    applyStimulus_reset();
    req = 4'b0001;
    doSegment(0, 3, 32'h11, 1'b1, 1'b1);
    checkOutput("single_starts", starts, 1);
    checkOutput("single_seg_cnt", seg_cnt, 16'h0001);
    checkOutput("single_pass", stream_pass, 4'hF);
    checkOutput("single_gnt_clear", gnt, '0);
    checkOutput("single_sb_empty", sb.size(), 0);

    // Fairness with all requests held, then completion.
    applyStimulus_reset();
    req = 4'hF;
    for (int k = 0; k < NR * SEGS; k++) doSegment(k % NR, 1, 32'h100 + k, 1'b1, 1'b0);
    checkOutput("all_done_lag", all_done, 1'b0);
    @(negedge clk);
    checkOutput("all_done", all_done, 1'b1);
    checkOutput("fair_seg_cnt", seg_cnt, 16'h4444);
    checkOutput("fair_pass", stream_pass, 4'hF);
    checkOutput("fair_starts", starts, NR * SEGS);
    repeat (3) @(negedge clk);
    checkOutput("done_idle_gnt", gnt, '0);
    checkOutput("all_done_sticky", all_done, 1'b1);

    // Fail propagation on stream 2.
    applyStimulus_reset();
    req = 4'b0100;
    doSegment(2, 2, 32'hA0, 1'b0, 1'b1);
    checkOutput("fail_pass", stream_pass, 4'b1011);
    checkOutput("fail_seg_cnt", seg_cnt, 16'h0100);
    req = 4'b0100;
    doSegment(2, 1, 32'hB0, 1'b1, 1'b1);
    checkOutput("fail_sticky", stream_pass, 4'b1011);
    checkOutput("fail_seg_cnt2", seg_cnt, 16'h0200);

    // Backpressure on stream 1 while stream 3 drives junk.
    applyStimulus_reset();
    s_valid[3] = 1'b1;
    s_last[3] = 1'b1;
    s_data[3*DW +: DW] = 32'hDEADBEEF;
    watch3 = 1'b1;
    req = 4'b0010;
    waitGrant(1);
    req = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1, 32'hC0 + b, b == 3);
      if (b < 3) @(negedge clk);
    end
    checkOutput("ready_drop", s_ready, '0);
    engineDone(1'b1);
    watch3 = 1'b0;
    s_valid[3] = 1'b0;
    s_last[3] = 1'b0;
    checkOutput("bp_seg_cnt", seg_cnt, 16'h0010);
    checkOutput("bp_sb_empty", sb.size(), 0);

    // Early done while still transferring.
    applyStimulus_reset();
    req = 4'b0001;
    waitGrant(0);
    req = 4'b0000;
    applyStimulus(0, 32'h55, 1'b0);
    engineDone(1'b1);
    checkOutput("early_pass", stream_pass, 4'b1110);
    checkOutput("early_seg_cnt", seg_cnt, 16'h0001);
    checkOutput("early_gnt", gnt, '0);
    req = 4'b0001;
    doSegment(0, 1, 32'h66, 1'b1, 1'b1);
    checkOutput("early_sticky", stream_pass, 4'b1110);
    checkOutput("early_seg_cnt2", seg_cnt, 16'h0002);

    // Reset in the middle of a transfer.
    applyStimulus_reset();
    req = 4'b0001;
    doSegment(0, 1, 32'h70, 1'b1, 1'b1);
    req = 4'b0001;
    waitGrant(0);
    req = 4'b0000;
    applyStimulus(0, 32'h71, 1'b0);
    applyStimulus(0, 32'h72, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_gnt", gnt, '0);
    checkOutput("mid_rst_enable", cmp_enable, 1'b0);
    checkOutput("mid_rst_seg_cnt", seg_cnt, 16'h0000);
    checkOutput("mid_rst_ready", s_ready, '0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    starts = 0;
    req = 4'b0001;
    doSegment(0, 1, 32'h73, 1'b1, 1'b1);
    checkOutput("post_rst_starts", starts, 1);
    checkOutput("post_rst_seg_cnt", seg_cnt, 16'h0001);

`ifdef CMP_SCHED_TIMEOUT_EN
    // Stalled stream 0 times out and the grant moves to stream 1.
    begin
      int n = 0;
      applyStimulus_reset();
      req = 4'b0011;
      waitGrant(0);
      req = 4'b0010;
      applyStimulus(0, 32'h80, 1'b0);
      while (gnt[0] && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput("timeout_cycles", n, TO);
      checkOutput("timeout_flag", timeout_flag, 1'b1);
      checkOutput("timeout_pass", stream_pass, 4'b1110);
      checkOutput("timeout_seg_cnt", seg_cnt, 16'h0001);
      doSegment(1, 1, 32'h90, 1'b1, 1'b1);
      checkOutput("timeout_next_cnt", seg_cnt, 16'h0011);
    end
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
